mem_port_arbiter: RTL

- Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester of the RV64 core.
- Enables the multi-cycle and unified-memory variants of the processor, where fetch and data access can no longer use separate combinational memories.
- Handles valid/ack handshakes on both requester sides and a request/ready handshake on the memory side, and sequences one transaction at a time.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_select.sv | 34 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The optional round-robin policy is enabled with ARB_ROUND_ROBIN_EN.
package arb_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/arb_select.sv
// Grant selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating priority; otherwise data always wins.
module arb_select
  import arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  // Priority resolution; a tie is the only case where the policy matters
  always_comb begin
    grant_valid = if_req | d_req;
    grant_id    = REQ_D;
    if (d_req && !if_req) begin
      grant_id = REQ_D;
    end else if (if_req && !d_req) begin
      grant_id = REQ_IF;
    end else if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_id = (last_grant == REQ_D) ? REQ_IF : REQ_D;
`else
      grant_id = REQ_D;
`endif
    end else begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for alternating grants on simultaneous requests.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              we_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              grant_valid_s;
  logic              grant_id_s;
  logic              grant_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant_r;

  // Remember who was served last so a tie goes to the other requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_r <= REQ_D;
    end else if (grant_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  arb_select u_select (
    .if_req      (if_req),
    .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant_r),
`endif
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Grants are only taken in IDLE, giving one arbitration point per access
  assign grant_s = (state_r == ARB_IDLE) && grant_valid_s;

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (grant_valid_s) begin
          next_state_s = (grant_id_s == REQ_D) ? ARB_BUSY_D : ARB_BUSY_I;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ready) begin
          next_state_s = ARB_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the granted request so the memory sees stable values even if the requester misbehaves
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_r  <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
    end else if (grant_s) begin
      if (grant_id_s == REQ_D) begin
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
        we_r    <= d_we;
      end else begin
        addr_r  <= if_addr;
        wdata_r <= '0;
        we_r    <= 1'b0;
      end
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      we_r    <= we_r;
    end
  end

  // Hold each requester's last read data between its own acks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      if_rdata_r <= if_ack ? mem_rdata : if_rdata_r;
      d_rdata_r  <= d_ack  ? mem_rdata : d_rdata_r;
    end
  end

  assign busy      = (state_r != ARB_IDLE);
  assign mem_req   = busy;
  assign mem_we    = busy & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign if_ack    = (state_r == ARB_BUSY_I) & mem_ready;
  assign d_ack     = (state_r == ARB_BUSY_D) & mem_ready;
  assign if_rdata  = if_ack ? mem_rdata : if_rdata_r;
  assign d_rdata   = d_ack  ? mem_rdata : d_rdata_r;

endmodule
